// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-issue CPU.
// Sequences fetch, decode, execute, memory access and write-back. It drives
// the register file, ALU and memory control lines and counts retired
// instructions.
//
// Handshake: imem_req / dmem_req stay high for as long as the FSM waits in
// FETCH / MEM. The matching *_ready input completes the access in the cycle
// it is sampled high at the rising edge. If ready does not arrive within
// TIMEOUT request cycles, the FSM parks in FAULT until reset.
module multicycle_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   input  logic                  alu_zero,
   output logic                  imem_req,
   output logic                  ir_load,
   output logic                  pc_en,
   output logic                  pc_src,
   output logic [REG_ADDR_W-1:0] rs_addr,
   output logic [REG_ADDR_W-1:0] rt_addr,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic                  rf_we,
   output logic                  wb_sel,
   output logic                  alu_src_imm,
   output logic [2:0]            alu_op,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  illegal,
   output logic                  fault,
   output logic [31:0]           retired,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   logic [31:0]       ir_q;
   logic [CNT_W-1:0]  wait_q;
   logic [31:0]       retired_q;
   logic              fault_q;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       is_rtype;
   logic       is_addi;
   logic       is_lw;
   logic       is_sw;
   logic       is_beq;
   logic       dec_legal;
   logic [2:0] dec_alu_op;
   logic       dec_imm;
   logic       unused_shamt;

   assign opcode       = ir_q[31:26];
   assign funct        = ir_q[5:0];
   assign unused_shamt = ^ir_q[10:6];

   // Instruction decode from the captured IR.
   always_comb begin
      is_rtype   = 1'b0;
      is_addi    = 1'b0;
      is_lw      = 1'b0;
      is_sw      = 1'b0;
      is_beq     = 1'b0;
      dec_legal  = 1'b0;
      dec_alu_op = ALU_ADD;
      dec_imm    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            is_rtype  = 1'b1;
            dec_legal = 1'b1;
            case (funct)
               FN_ADD:  dec_alu_op = ALU_ADD;
               FN_SUB:  dec_alu_op = ALU_SUB;
               FN_AND:  dec_alu_op = ALU_AND;
               FN_OR:   dec_alu_op = ALU_OR;
               FN_SLT:  dec_alu_op = ALU_SLT;
               default: dec_legal  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            is_addi   = 1'b1;
            dec_legal = 1'b1;
            dec_imm   = 1'b1;
         end
         OP_LW: begin
            is_lw     = 1'b1;
            dec_legal = 1'b1;
            dec_imm   = 1'b1;
         end
         OP_SW: begin
            is_sw     = 1'b1;
            dec_legal = 1'b1;
            dec_imm   = 1'b1;
         end
         OP_BEQ: begin
            is_beq     = 1'b1;
            dec_legal  = 1'b1;
            dec_alu_op = ALU_SUB;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Control FSM: state, IR, wait counter, retired count and sticky fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= 32'd0;
         wait_q    <= '0;
         retired_q <= 32'd0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  ir_q    <= instr;
                  wait_q  <= '0;
                  state_q <= S_DECODE;
               end else if (wait_q == WAIT_LAST) begin
                  wait_q  <= '0;
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_DECODE: begin
               wait_q  <= '0;
               state_q <= dec_legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
               wait_q <= '0;
               if (is_beq) begin
                  retired_q <= retired_q + 32'd1;
                  state_q   <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  state_q <= S_MEM;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  wait_q <= '0;
                  if (is_sw) begin
                     retired_q <= retired_q + 32'd1;
                     state_q   <= S_FETCH;
                  end else begin
                     state_q <= S_WB;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  wait_q  <= '0;
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_WB: begin
               wait_q    <= '0;
               retired_q <= retired_q + 32'd1;
               state_q   <= S_FETCH;
            end
            S_FAULT: begin
               fault_q <= 1'b1;
            end
            default: begin
               wait_q  <= '0;
               fault_q <= 1'b1;
               state_q <= S_FAULT;
            end
         endcase
      end
   end

   // Register addresses come straight from the IR, so they hold until the next fetch.
   always_comb begin
      rs_addr = REG_ADDR_W'(ir_q[25:21]);
      rt_addr = REG_ADDR_W'(ir_q[20:16]);
      wr_addr = is_rtype ? REG_ADDR_W'(ir_q[15:11]) : REG_ADDR_W'(ir_q[20:16]);
   end

   // Per-state control decode; requests and pulses are held low while rst is high.
   always_comb begin
      imem_req    = 1'b0;
      ir_load     = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
         end
         S_DECODE: begin
            if (!dec_legal) begin
               illegal = 1'b1;
               pc_en   = 1'b1;
            end
         end
         S_EXEC: begin
            alu_op      = dec_alu_op;
            alu_src_imm = dec_imm;
            if (is_beq) begin
               pc_en  = 1'b1;
               pc_src = alu_zero;
            end
         end
         S_MEM: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            dmem_req    = 1'b1;
            dmem_we     = is_sw;
            pc_en       = is_sw & dmem_ready;
         end
         S_WB: begin
            alu_op      = dec_alu_op;
            alu_src_imm = dec_imm;
            rf_we       = 1'b1;
            wb_sel      = is_lw;
            pc_en       = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         imem_req = 1'b0;
         ir_load  = 1'b0;
         pc_en    = 1'b0;
         pc_src   = 1'b0;
         rf_we    = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign fault   = fault_q;
   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction table driven through
// the FSM, plus hand-written reset, timeout, wrap and mid-access reset sequences.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        imem_req, ir_load, pc_en, pc_src, rf_we, wb_sel, alu_src_imm;
   logic        dmem_req, dmem_we, illegal, fault;
   logic [4:0]  rs_addr, rt_addr, wr_addr;
   logic [2:0]  alu_op, state;
   logic [31:0] retired;

   int tests = 0;
   int fails = 0;
   logic [31:0] model_retired = 32'd0;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [2:0]  alu_op;
      logic        src_imm;
      logic [4:0]  mem_cyc;
      logic        mem_we;
      logic [1:0]  we_cnt;
      logic [4:0]  wr;
      logic        wb_sel;
      logic [1:0]  ill_cnt;
      logic        pc_src;
      logic [5:0]  cycles;
      logic [31:0] retired;
      logic [2:0]  st_after;
   } res_t;

   typedef struct {
      logic [31:0] ins;
      logic        zero;
      int          ilat;
      int          dlat;
      res_t        exp;
   } vec_t;

   res_t exp_q[$];
   vec_t vecs[14];

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req),
      .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src), .rs_addr(rs_addr),
      .rt_addr(rt_addr), .wr_addr(wr_addr), .rf_we(rf_we), .wb_sel(wb_sel),
      .alu_src_imm(alu_src_imm), .alu_op(alu_op), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .illegal(illegal), .fault(fault), .retired(retired),
      .state(state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] ins, input logic zero, input int ilat,
                               input int dlat, input int rs, input int rt, input int op,
                               input int imm, input int memc, input int memwe, input int wecnt,
                               input int wr, input int wbsel, input int ill, input int psrc,
                               input int cyc);
      vec_t v;
      v.ins  = ins;
      v.zero = zero;
      v.ilat = ilat;
      v.dlat = dlat;
      v.exp  = '0;
      v.exp.rs      = 5'(rs);
      v.exp.rt      = 5'(rt);
      v.exp.alu_op  = 3'(op);
      v.exp.src_imm = 1'(imm);
      v.exp.mem_cyc = 5'(memc);
      v.exp.mem_we  = 1'(memwe);
      v.exp.we_cnt  = 2'(wecnt);
      v.exp.wr      = 5'(wr);
      v.exp.wb_sel  = 1'(wbsel);
      v.exp.ill_cnt = 2'(ill);
      v.exp.pc_src  = 1'(psrc);
      v.exp.cycles  = 6'(cyc);
      return v;
   endfunction

   // Scoreboard: pop the oldest expectation and compare every field.
   task automatic sb_check(input string tag, input res_t o);
      res_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s_sb: got result with empty expected queue", tag);
         return;
      end
      e = exp_q.pop_front();
      cmp({tag, "_rs"},      32'(o.rs),       32'(e.rs));
      cmp({tag, "_rt"},      32'(o.rt),       32'(e.rt));
      cmp({tag, "_alu_op"},  32'(o.alu_op),   32'(e.alu_op));
      cmp({tag, "_src_imm"}, 32'(o.src_imm),  32'(e.src_imm));
      cmp({tag, "_mem_cyc"}, 32'(o.mem_cyc),  32'(e.mem_cyc));
      cmp({tag, "_mem_we"},  32'(o.mem_we),   32'(e.mem_we));
      cmp({tag, "_we_cnt"},  32'(o.we_cnt),   32'(e.we_cnt));
      cmp({tag, "_wr"},      32'(o.wr),       32'(e.wr));
      cmp({tag, "_wb_sel"},  32'(o.wb_sel),   32'(e.wb_sel));
      cmp({tag, "_illegal"}, 32'(o.ill_cnt),  32'(e.ill_cnt));
      cmp({tag, "_pc_src"},  32'(o.pc_src),   32'(e.pc_src));
      cmp({tag, "_cycles"},  32'(o.cycles),   32'(e.cycles));
      cmp({tag, "_retired"}, o.retired,       e.retired);
      cmp({tag, "_state"},   32'(o.st_after), 32'(e.st_after));
   endtask

   // Driver: runs one instruction from FETCH until its pc_en pulse, recording what the DUT did.
   // Entered and left 1 ns after a rising edge, with the DUT in FETCH.
   task automatic run_instr(input string tag, input vec_t v);
      res_t e, o;
      int fc, mc;
      bit done;
      logic [2:0] st;
      e = v.exp;
      if (e.ill_cnt == 2'd0) model_retired = model_retired + 32'd1;
      e.retired  = model_retired;
      e.st_after = 3'd0;
      exp_q.push_back(e);
      o = '0;
      fc = 0;
      mc = 0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         st = state;
         instr      = v.ins;
         alu_zero   = v.zero;
         imem_ready = (st == 3'd0) && (fc == v.ilat - 1);
         dmem_ready = (st == 3'd3) && (mc == v.dlat - 1);
         #1;
         o.cycles = o.cycles + 6'd1;
         if (st == 3'd1) begin
            o.rs = rs_addr;
            o.rt = rt_addr;
         end
         if (st == 3'd2) begin
            o.alu_op  = alu_op;
            o.src_imm = alu_src_imm;
         end
         if (dmem_req) begin
            o.mem_cyc = o.mem_cyc + 5'd1;
            o.mem_we  = o.mem_we | dmem_we;
         end
         if (rf_we) begin
            o.we_cnt = o.we_cnt + 2'd1;
            o.wr     = wr_addr;
            o.wb_sel = wb_sel;
         end
         if (illegal) o.ill_cnt = o.ill_cnt + 2'd1;
         if (pc_en) begin
            o.pc_src = pc_src;
            done = 1'b1;
         end
         if (st == 3'd0) fc++;
         if (st == 3'd3) mc++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_pc_en: got no pc_en within 60 cycles expected one", tag);
      end
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      o.retired  = retired;
      o.st_after = state;
      sb_check(tag, o);
   endtask

   // Reset: one cycle of rst, returns 1 ns after the reset edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_retired = 32'd0;
   endtask

   localparam logic [31:0] I_LW = 32'h8C850008;
   localparam logic [31:0] I_SW = 32'hACA60004;

   initial begin
      int mc;
      bit seen_fault;
      vec_t sw_v;

      // ---------------- reset, with imem_ready high to check gating
      rst = 1'b1;
      imem_ready = 1'b1;
      instr = 32'hFFFFFFFF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cmp("rst_state",    32'(state),    32'd0);
      cmp("rst_retired",  retired,       32'd0);
      cmp("rst_fault",    32'(fault),    32'd0);
      cmp("rst_imem_req", 32'(imem_req), 32'd0);
      cmp("rst_ir_load",  32'(ir_load),  32'd0);
      cmp("rst_pc_en",    32'(pc_en),    32'd0);
      cmp("rst_rf_we",    32'(rf_we),    32'd0);
      cmp("rst_dmem_req", 32'(dmem_req), 32'd0);
      cmp("rst_illegal",  32'(illegal),  32'd0);
      cmp("rst_rs_addr",  32'(rs_addr),  32'd0);
      imem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---------------- instruction table
      //                ins           z  il dl rs  rt op im mc mw we wr ws il ps cyc
      vecs[0]  = mk(32'h00221820, 0, 1, 1,  1,  2, 0, 0, 0, 0, 1,  3, 0, 0, 0, 4);  // add $3,$1,$2
      vecs[1]  = mk(I_LW,         0, 1, 3,  4,  5, 0, 1, 3, 0, 1,  5, 1, 0, 0, 7);  // lw $5,8($4), slow dmem
      vecs[2]  = mk(32'h10220004, 1, 1, 1,  1,  2, 1, 0, 0, 0, 0,  0, 0, 0, 1, 3);  // beq taken
      vecs[3]  = mk(32'h10220004, 0, 1, 1,  1,  2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3);  // beq not taken
      vecs[4]  = mk(32'hFC000000, 0, 1, 1,  0,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2);  // opcode 0x3F
      vecs[5]  = mk(32'h01093822, 0, 1, 1,  8,  9, 1, 0, 0, 0, 1,  7, 0, 0, 0, 4);  // sub
      vecs[6]  = mk(32'h016C5024, 0, 1, 1, 11, 12, 2, 0, 0, 0, 1, 10, 0, 0, 0, 4);  // and
      vecs[7]  = mk(32'h01CF6825, 0, 1, 1, 14, 15, 3, 0, 0, 0, 1, 13, 0, 0, 0, 4);  // or
      vecs[8]  = mk(32'h0232802A, 0, 1, 1, 17, 18, 4, 0, 0, 0, 1, 16, 0, 0, 0, 4);  // slt
      vecs[9]  = mk(32'h2274FFFF, 0, 3, 1, 19, 20, 0, 1, 0, 0, 1, 20, 0, 0, 0, 6);  // addi, slow imem
      vecs[10] = mk(I_SW,         0, 1, 1,  5,  6, 0, 1, 1, 1, 0,  0, 0, 0, 0, 4);  // sw $6,4($5)
      vecs[11] = mk(32'h00221821, 0, 1, 1,  1,  2, 0, 0, 0, 0, 0,  0, 0, 1, 0, 2);  // bad funct
      vecs[12] = mk(32'h00220020, 0, 1, 1,  1,  2, 0, 0, 0, 0, 1,  0, 0, 0, 0, 4);  // add to $0
      vecs[13] = mk(32'h00221820, 0,16, 1,  1,  2, 0, 0, 0, 0, 1,  3, 0, 0, 0, 19); // ready on last fetch cycle
      for (int i = 0; i < 14; i++) run_instr($sformatf("v%0d", i), vecs[i]);
      cmp("sb_drained", 32'(exp_q.size()), 32'd0);

      // ---------------- fetch timeout
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         imem_ready = 1'b0;
         #1;
         if (i == 15) begin
            cmp("fto_last_wait_state", 32'(state), 32'd0);
            cmp("fto_last_wait_req",   32'(imem_req), 32'd1);
         end
      end
      @(negedge clk);
      imem_ready = 1'b1;
      #1;
      cmp("fto_state",    32'(state),    32'd7);
      cmp("fto_fault",    32'(fault),    32'd1);
      cmp("fto_imem_req", 32'(imem_req), 32'd0);
      cmp("fto_ir_load",  32'(ir_load),  32'd0);
      cmp("fto_pc_en",    32'(pc_en),    32'd0);
      cmp("fto_rf_we",    32'(rf_we),    32'd0);
      cmp("fto_dmem_req", 32'(dmem_req), 32'd0);
      @(negedge clk);
      #1;
      cmp("fto_sticky_state", 32'(state), 32'd7);
      do_reset();
      @(negedge clk);
      #1;
      cmp("fto_clr_fault", 32'(fault), 32'd0);
      cmp("fto_clr_state", 32'(state), 32'd0);

      // ---------------- data memory timeout (lw, dmem never ready)
      mc = 0;
      seen_fault = 1'b0;
      for (int c = 0; c < 40 && !seen_fault; c++) begin
         @(negedge clk);
         instr = I_LW;
         imem_ready = (state == 3'd0);
         dmem_ready = 1'b0;
         #1;
         if (state == 3'd3) mc++;
         if (state == 3'd7) seen_fault = 1'b1;
      end
      imem_ready = 1'b0;
      cmp("dto_mem_cycles", 32'(mc),       32'd16);
      cmp("dto_state",      32'(state),    32'd7);
      cmp("dto_fault",      32'(fault),    32'd1);
      cmp("dto_dmem_req",   32'(dmem_req), 32'd0);
      cmp("dto_rf_we",      32'(rf_we),    32'd0);
      do_reset();

      // ---------------- retired wrap
      force dut.retired_q = 32'hFFFFFFFF;
      #1;
      release dut.retired_q;
      model_retired = 32'hFFFFFFFF;
      sw_v = mk(I_SW, 0, 1, 1, 5, 6, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4);
      run_instr("wrap_sw", sw_v);
      cmp("wrap_retired_zero", retired, 32'd0);

      // ---------------- reset in the middle of MEM
      @(negedge clk);
      instr = I_LW;
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      cmp("rmem_in_mem_state", 32'(state),    32'd3);
      cmp("rmem_in_mem_req",   32'(dmem_req), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      cmp("rmem_rst_cycle_req", 32'(dmem_req), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_retired = 32'd0;
      @(negedge clk);
      #1;
      cmp("rmem_after_req",     32'(dmem_req), 32'd0);
      cmp("rmem_after_state",   32'(state),    32'd0);
      cmp("rmem_after_retired", retired,       32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
